// File: rtl/fdc_seek_ctrl.sv
// Floppy disk controller seek sequencer: motor spin-up, head stepping,
// settle timing, optional track verify against the sector header, and
// idle motor shut-off counted in index pulses.
module fdc_seek_ctrl #(
  parameter int SYS_CLK       = 8000000,
  parameter int STEP_CLKS     = 48000,
  parameter int PULSE_CLKS    = 32,
  parameter int SETTLE_CLKS   = 120000,
  parameter int TRACKS        = 85,
  parameter int SPINUP_IDX    = 6,
  parameter int TIMEOUT_IDX   = 5,
  parameter int MOTOR_OFF_IDX = 10,
  parameter int RESTORE_MAX   = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_start,
  input  logic [1:0] cmd_op,
  input  logic       cmd_verify,
  input  logic [6:0] cmd_track,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] cur_track,
  output logic       select,
  output logic       motor_on,
  output logic       step_in,
  output logic       step_out,
  input  logic       ready,
  input  logic       index,
  input  logic       track0,
  input  logic       sector_hdr,
  input  logic [6:0] drive_track
);

  // state   | meaning
  // IDLE    | waiting for cmd_start, counting idle index pulses for motor off
  // SPINUP  | motor just started, waiting SPINUP_IDX index pulses
  // STEP_HI | step pulse asserted for PULSE_CLKS cycles
  // STEP_LO | remainder of the step period
  // SETTLE  | head settle time after last (or no) step
  // VERIFY  | waiting for a sector header or index timeout
  // FINISH  | publish result, pulse done
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SPINUP  = 3'd1;
  localparam logic [2:0] S_STEP_HI = 3'd2;
  localparam logic [2:0] S_STEP_LO = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_VERIFY  = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic [1:0] OP_RESTORE  = 2'd0;
  localparam logic [1:0] OP_SEEK     = 2'd1;
  localparam logic [1:0] OP_STEP_IN  = 2'd2;
  localparam logic [1:0] OP_STEP_OUT = 2'd3;

  localparam logic [1:0] DEC_SETTLE = 2'd0;
  localparam logic [1:0] DEC_IN     = 2'd1;
  localparam logic [1:0] DEC_OUT    = 2'd2;
  localparam logic [1:0] DEC_FAIL   = 2'd3;

  // Elaboration-time sanity check on the timing parameters.
  if (SYS_CLK <= 0 || PULSE_CLKS < 1 || STEP_CLKS <= PULSE_CLKS || SETTLE_CLKS < 1)
  begin : g_bad_params
    $error("fdc_seek_ctrl: inconsistent timing parameters");
  end

  logic [2:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic        verify_q, verify_d;
  logic [6:0]  trk_q, trk_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        res_err_q, res_err_d;
  logic [6:0]  cur_track_q, cur_track_d;
  logic        motor_on_q, motor_on_d;
  logic        select_q, select_d;
  logic        step_in_q, step_in_d;
  logic        step_out_q, step_out_d;
  logic        dir_in_q, dir_in_d;
  logic        index_prev_q, index_prev_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  idx_cnt_q, idx_cnt_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic [6:0]  step_cnt_q, step_cnt_d;

  logic        idx_evt;
  logic        apply_dec;
  logic [1:0]  op_sel;
  logic [6:0]  trk_sel;
  logic [6:0]  cnt_sel;
  logic [1:0]  dec;
  logic        dec_zero;

  assign idx_evt = index_prev_q & ~index;

  // Step decision; in IDLE it looks at the raw command so a command with the
  // motor already running can start stepping on the very next cycle.
  always_comb begin
    op_sel   = (state_q == S_IDLE) ? cmd_op    : op_q;
    trk_sel  = (state_q == S_IDLE) ? cmd_track : trk_q;
    cnt_sel  = (state_q == S_IDLE) ? 7'd0      : step_cnt_q;
    dec      = DEC_SETTLE;
    dec_zero = 1'b0;
    case (op_sel)
      OP_RESTORE: begin
        if (track0)                          dec_zero = 1'b1;
        else if (cnt_sel >= 7'(RESTORE_MAX)) dec      = DEC_FAIL;
        else                                 dec      = DEC_IN;
      end
      OP_SEEK: begin
        if (trk_sel >= 7'(TRACKS))     dec = DEC_FAIL;
        else if (trk_sel < cur_track_q) dec = DEC_IN;
        else if (trk_sel > cur_track_q) dec = DEC_OUT;
      end
      OP_STEP_IN: begin
        if (cnt_sel == 7'd0) begin
          if (track0) dec_zero = 1'b1;
          else        dec      = DEC_IN;
        end
      end
      default: begin
        if (cnt_sel == 7'd0 && cur_track_q != 7'(TRACKS - 1)) dec = DEC_OUT;
      end
    endcase
  end

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    verify_d     = verify_q;
    trk_d        = trk_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    res_err_d    = res_err_q;
    cur_track_d  = cur_track_q;
    motor_on_d   = motor_on_q;
    dir_in_d     = dir_in_q;
    index_prev_d = index;
    tmr_d        = tmr_q;
    idx_cnt_d    = idx_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    step_cnt_d   = step_cnt_q;
    apply_dec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (idx_evt && motor_on_q) begin
          if (idle_cnt_q >= 8'(MOTOR_OFF_IDX - 1)) begin
            motor_on_d = 1'b0;
            idle_cnt_d = 8'd0;
          end else begin
            idle_cnt_d = idle_cnt_q + 8'd1;
          end
        end
        if (cmd_start) begin
          op_d       = cmd_op;
          verify_d   = cmd_verify;
          trk_d      = cmd_track;
          busy_d     = 1'b1;
          motor_on_d = 1'b1;
          error_d    = 1'b0;
          res_err_d  = 1'b0;
          step_cnt_d = 7'd0;
          idle_cnt_d = 8'd0;
          if (motor_on_q) begin
            apply_dec = 1'b1;
          end else begin
            state_d   = S_SPINUP;
            idx_cnt_d = 8'(SPINUP_IDX);
          end
        end
      end
      S_SPINUP: begin
        if (idx_cnt_q == 8'd0)  apply_dec = 1'b1;
        else if (idx_evt)       idx_cnt_d = idx_cnt_q - 8'd1;
      end
      S_STEP_HI: begin
        if (tmr_q == 32'd0) begin
          if (dir_in_q) cur_track_d = (cur_track_q == 7'd0) ? 7'd0 : cur_track_q - 7'd1;
          else          cur_track_d = cur_track_q + 7'd1;
          step_cnt_d = step_cnt_q + 7'd1;
          tmr_d      = 32'(STEP_CLKS - PULSE_CLKS - 1);
          state_d    = S_STEP_LO;
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_STEP_LO: begin
        if (tmr_q == 32'd0) apply_dec = 1'b1;
        else                tmr_d     = tmr_q - 32'd1;
      end
      S_SETTLE: begin
        if (tmr_q == 32'd0) begin
          // Step-in/step-out never verify; op[1] marks those two commands.
          if (verify_q && !op_q[1]) begin
            state_d   = S_VERIFY;
            idx_cnt_d = 8'(TIMEOUT_IDX);
          end else begin
            state_d = S_FINISH;
          end
        end else begin
          tmr_d = tmr_q - 32'd1;
        end
      end
      S_VERIFY: begin
        if (ready && sector_hdr) begin
          res_err_d = (drive_track != cur_track_q);
          state_d   = S_FINISH;
        end else if (idx_evt) begin
          if (idx_cnt_q <= 8'd1) begin
            res_err_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            idx_cnt_d = idx_cnt_q - 8'd1;
          end
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        error_d = res_err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (apply_dec) begin
      case (dec)
        DEC_IN: begin
          state_d  = S_STEP_HI;
          dir_in_d = 1'b1;
          tmr_d    = 32'(PULSE_CLKS - 1);
        end
        DEC_OUT: begin
          state_d  = S_STEP_HI;
          dir_in_d = 1'b0;
          tmr_d    = 32'(PULSE_CLKS - 1);
        end
        DEC_FAIL: begin
          res_err_d = 1'b1;
          state_d   = S_FINISH;
        end
        default: begin
          if (dec_zero) cur_track_d = 7'd0;
          tmr_d   = 32'(SETTLE_CLKS - 1);
          state_d = S_SETTLE;
        end
      endcase
    end
  end

  // Output flops decoded from next state so pulses are glitch-free and
  // drop immediately with the asynchronous reset.
  always_comb begin
    step_in_d  = (state_d == S_STEP_HI) &&  dir_in_d;
    step_out_d = (state_d == S_STEP_HI) && !dir_in_d;
    select_d   = motor_on_d | busy_d;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= 2'd0;
      verify_q     <= 1'b0;
      trk_q        <= 7'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      res_err_q    <= 1'b0;
      cur_track_q  <= 7'd0;
      motor_on_q   <= 1'b0;
      select_q     <= 1'b0;
      step_in_q    <= 1'b0;
      step_out_q   <= 1'b0;
      dir_in_q     <= 1'b0;
      index_prev_q <= 1'b0;
      tmr_q        <= 32'd0;
      idx_cnt_q    <= 8'd0;
      idle_cnt_q   <= 8'd0;
      step_cnt_q   <= 7'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      verify_q     <= verify_d;
      trk_q        <= trk_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      res_err_q    <= res_err_d;
      cur_track_q  <= cur_track_d;
      motor_on_q   <= motor_on_d;
      select_q     <= select_d;
      step_in_q    <= step_in_d;
      step_out_q   <= step_out_d;
      dir_in_q     <= dir_in_d;
      index_prev_q <= index_prev_d;
      tmr_q        <= tmr_d;
      idx_cnt_q    <= idx_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cur_track = cur_track_q;
  assign select    = select_q;
  assign motor_on  = motor_on_q;
  assign step_in   = step_in_q;
  assign step_out  = step_out_q;

endmodule

// File: doc/fdc_seek_ctrl.md
FDC_SEEK_CTRL -- requirements
Module: fdc_seek_ctrl

Interface
REQ-001 SHALL have parameters: SYS_CLK, 8000000, clock frequency in Hz.
REQ-002 SHALL have parameters: STEP_CLKS, 48000, step period in clk cycles (6 ms).
REQ-003 SHALL have parameters: PULSE_CLKS, 32, step pulse width in clk cycles (4 us).
REQ-004 SHALL have parameters: SETTLE_CLKS, 120000, head settle time after the last step (15 ms).
REQ-005 SHALL have parameters: TRACKS, 85, number of valid tracks.
REQ-006 SHALL have parameters: SPINUP_IDX, 6, index pulses to wait after motor start.
REQ-007 SHALL have parameters: TIMEOUT_IDX, 5, index pulses allowed for verify.
REQ-008 SHALL have parameters: MOTOR_OFF_IDX, 10, idle index pulses before motor off.
REQ-009 SHALL have parameters: RESTORE_MAX, 90, max step-in pulses during restore.
REQ-010 SHALL have ports, clock and reset first:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- cmd_start  in  1  one-cycle command strobe
- cmd_op  in  2  0 restore, 1 seek, 2 step-in, 3 step-out
- cmd_verify  in  1  verify track after restore/seek
- cmd_track  in  7  seek target
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  result of last command, valid from done
- cur_track  out  7  controller track register
- select  out  1  drive select
- motor_on  out  1  drive motor
- step_in  out  1  step toward track 0
- step_out  out  1  step away from track 0
- ready  in  1  drive ready
- index  in  1  index, active-low pulse
- track0  in  1  head at track 0
- sector_hdr  in  1  sector header under head
- drive_track  in  7  track ID read from header

Function
REQ-011 SHALL count an index event on each falling edge of index, using a registered previous-index value.
REQ-012 SHALL use states IDLE, SPINUP, STEP_HI, STEP_LO, SETTLE, VERIFY, FINISH.
REQ-013 SHALL sample cmd_start only in IDLE and ignore it while busy=1.
REQ-014 SHALL latch cmd_op, cmd_verify and cmd_track, set busy=1 and motor_on=1 on the cycle after cmd_start.
REQ-015 SHALL enter SPINUP if motor_on was 0 at cmd_start, waiting SPINUP_IDX index events; otherwise it SHALL go straight to step decision.
REQ-016 SHALL make the step decision as follows:
- restore: step_in while track0=0.
- seek: step_in if cmd_track<cur_track, step_out if greater, no step if equal.
- step-in / step-out: exactly one step.
REQ-017 SHALL finish a seek with cmd_track>=TRACKS in FINISH with error=1, no steps and cur_track unchanged.
REQ-018 SHALL drive step_in or step_out high for PULSE_CLKS cycles in STEP_HI, then stay in STEP_LO for STEP_CLKS-PULSE_CLKS cycles.
REQ-019 SHALL update cur_track at the end of STEP_HI: -1 for step_in, +1 for step_out.
REQ-020 SHALL never assert step_in and step_out together.
REQ-021 SHALL handle step-in with track0=1 by not pulsing, setting cur_track=0 and error=0.
REQ-022 SHALL handle step-out with cur_track=TRACKS-1 by not pulsing and setting error=0.
REQ-023 SHALL end restore when track0=1: cur_track=0.
REQ-024 SHALL end restore with error=1 if RESTORE_MAX pulses are issued with track0 still 0.
REQ-025 SHALL enter SETTLE after the last step, or immediately when no step is needed, for SETTLE_CLKS cycles.
REQ-026 SHALL after SETTLE go to VERIFY if cmd_verify=1 (restore/seek only), else to FINISH.
REQ-027 SHALL in VERIFY wait for ready=1 and sector_hdr=1, then set error=(drive_track!=cur_track).
REQ-028 SHALL set error=1 if TIMEOUT_IDX index events pass in VERIFY first.
REQ-029 SHALL in FINISH pulse done for one cycle, clear busy and return to IDLE.
REQ-030 SHALL hold error until the next cmd_start, which clears it.
REQ-031 SHALL clear motor_on after MOTOR_OFF_IDX consecutive index events in IDLE; any cmd_start SHALL reset that count.
REQ-032 SHALL assert select whenever motor_on=1 or busy=1.

Reset
REQ-033 SHALL on reset, asynchronously, force state IDLE and all outputs 0: busy, done, error, cur_track, select, motor_on, step_in, step_out.
REQ-034 SHALL on reset mid-command drop any active step pulse immediately and produce no done.
REQ-035 SHALL clear all internal counters on reset.

Verification
REQ-036 SHALL be verified by: motor off, restore, track0 rises after 3 pulses -> SPINUP waits 6 index events, exactly 3 step_in pulses of 32 clk at 48000-clk spacing, cur_track=0, done, error=0.
REQ-037 SHALL be verified by: cur_track=0, seek to 10 without verify -> 10 step_out pulses, SETTLE 120000 clk, done, cur_track=10.
REQ-038 SHALL be verified by: seek to 5 with verify, drive_track=4 at sector_hdr -> done with error=1, and error=0 when drive_track=5.
REQ-039 SHALL be verified by: verify with sector_hdr never asserted -> error=1 after exactly 5 index falling edges.
REQ-040 SHALL be verified by: seek to 90 -> done with error=1 and no step pulses; cmd_start during busy ignored; reset in STEP_HI -> step_out low at once.
REQ-041 SHALL be verified by: 10 idle index events after done -> motor_on=0 and select=0.
